rr_arb4_sel: RTL and testbench
==============================

# rr_arb4_sel

Four-requester round-robin arbiter that produces the registered 2-bit grant index feeding the 2-to-4 one-hot decoder stage. It accepts four request lines, grants one requester at a time, holds the grant until the granted client acknowledges completion, and rotates priority so no requester starves. The `gnt_idx` output connects directly to the decoder's 2-bit select input. `gnt_valid` qualifies the decoder's one-hot output.

## Interface
- `MAX_HOLD`, default 16: maximum grant length in cycles before a forced release. Used only when `ARB_TIMEOUT_EN` is defined. Legal range 2..255.
- `clk`: input, 1 bit. Single clock, rising edge.
- `rst_n`: input, 1 bit. Reset is asynchronous and active-low.
- `req`: input, 4 bits. Request lines; bit n is requester n.
- `ack`: input, 1 bit. Pulse from the granted client meaning "transfer done, release grant".
- `gnt_idx`: output, 2 bits, registered. Index of the granted requester, feeding the decoder select.
- `gnt_valid`: output, 1 bit, registered. High while a grant is active.
- `tmo`: output, 1 bit, registered. One-cycle pulse when a grant is forcibly revoked. Tied to 0 when `ARB_TIMEOUT_EN` is not defined.

## Operation
- The state machine has two states.
  - **IDLE**: `gnt_valid=0`.
  - **BUSY**: `gnt_valid=1`.
- Rotating pointer `ptr[1:0]` names the highest-priority requester. The search order is ptr, ptr+1, ptr+2, ptr+3, all mod 4.
- **IDLE to BUSY:** when `req != 0`, the arbiter picks the first set bit in search order. It loads `gnt_idx` with that index, sets `gnt_valid=1`, and clears the hold counter.
- **BUSY, `ack=0`:**
  - `gnt_idx` is frozen.
  - Changes on `req` are ignored, including the granted requester dropping its `req`.
  - `ack` is the only normal release.
- **BUSY, `ack=1`:**
  - `ptr` becomes `gnt_idx+1` (wraps 3 to 0).
  - If any `req` bit is set, the arbiter grants the next winner immediately, searching from the new `ptr`. This is a back-to-back grant and `gnt_valid` stays 1.
  - If no `req` bit is set, the FSM goes to IDLE.
  - The releasing requester may win again only if it is the sole requester.
- `ack` in IDLE is ignored.
- `ptr` changes only on a release: ack, or timeout when `ARB_TIMEOUT_EN` is defined.

## Timing
- **Reset values:**
  - State = IDLE
  - `gnt_idx=2'b00`
  - `gnt_valid=0`
  - `tmo=0`
  - `ptr=0`
  - Hold counter = 0
- Reset takes effect immediately on the `rst_n` falling edge, including in the middle of a grant. The first grant after reset is evaluated on the first rising edge with `rst_n=1`.
- **Latency:** a request sampled at edge k gives `gnt_valid=1` after edge k. There is one cycle of request-to-grant latency.
- **Release:** `ack` sampled at edge k updates `gnt_idx`/`gnt_valid` after edge k. Handover has no dead cycle.
- All outputs are glitch-free register outputs. The downstream decoder is combinational on `gnt_idx`.

## Configuration
- `ARB_TIMEOUT_EN` defined:
  - An 8-bit hold counter increments each BUSY cycle without `ack`.
  - When the counter reaches `MAX_HOLD-1` with `ack=0`, the next edge releases the grant exactly as an ack would: `ptr` advances and a back-to-back grant is allowed.
  - `tmo` pulses high for that one cycle.
  - If `ack` and timeout coincide, `ack` wins and `tmo` stays 0.
- `ARB_TIMEOUT_EN` not defined:
  - No counter is built.
  - `tmo` is constant 0.
  - A grant is held indefinitely until `ack`.

## Structure
- Shared package `arb_pkg` holds:
  - State encoding constants `ST_IDLE=1'b0` and `ST_BUSY=1'b1`.
  - Requester count `N_REQ=4`.
  - Index width `IDX_W=2`.
- One combinational sub-module, `rr_pick4`:
  - Inputs `req[3:0]` and `ptr[1:0]`.
  - Outputs `idx[1:0]` and `any`.
  - It is instantiated once and used for both the IDLE grant and the back-to-back grant.

## Test plan
- Reset, then `req=4'b0000` for 5 cycles: `gnt_valid=0` and `gnt_idx=0` throughout, `tmo=0`.
- `req=4'b1010` from IDLE with `ptr=0`: the cycle after, `gnt_idx=2'b01` and `gnt_valid=1`. `ack` pulse → `gnt_idx=2'b11` on the next cycle with no gap. `ack` with `req=0` → IDLE, `ptr=0`.
- `req=4'b1111` held and `ack` pulsed every 3rd cycle: grant sequence 0,1,2,3,0; each grant lasts exactly 3 cycles.
- Granted requester 2 drops `req` mid-grant without `ack`: `gnt_idx` stays 2'b10 until `ack`.
- `ARB_TIMEOUT_EN`, `MAX_HOLD=4`, `req=4'b0001`, no `ack`:
  - Release after 4 BUSY cycles, with a one-cycle `tmo` pulse.
  - Requester 0 is re-granted back-to-back because it is the sole requester.
  - Repeat the scenario with `ack` on the 4th cycle: `tmo` stays 0.
- Assert `rst_n=0` asynchronously mid-grant (`gnt_idx=3`): `gnt_valid` and `gnt_idx` go to 0 before the next clock edge, and `ptr` returns to 0.

Source files
------------

// File: rtl/arb_pkg.sv
// Shared definitions for the four-requester round-robin arbiter slice:
// FSM state encoding, requester count and grant index width.
package arb_pkg;

    localparam int N_REQ = 4;
    localparam int IDX_W = 2;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_BUSY = 1'b1
    } state_t;

endpackage

// File: rtl/rr_arb4_sel_if.sv
// Request/grant bundle between the clients and rr_arb4_sel; the arbiter
// takes the slave view, the client side (or a bench) takes the master view.
interface rr_arb4_sel_if;

    logic [arb_pkg::N_REQ-1:0] req;
    logic                      ack;
    logic [arb_pkg::IDX_W-1:0] gnt_idx;
    logic                      gnt_valid;
    logic                      tmo;

    modport master (
        output req,
        output ack,
        input  gnt_idx,
        input  gnt_valid,
        input  tmo
    );

    modport slave (
        input  req,
        input  ack,
        output gnt_idx,
        output gnt_valid,
        output tmo
    );

endinterface

// File: rtl/rr_pick4.sv
// Combinational round-robin picker: first set request bit searching
// ptr, ptr+1, ptr+2, ptr+3 (mod 4).
module rr_pick4
    import arb_pkg::*;
(
    input  logic [N_REQ-1:0] req,
    input  logic [IDX_W-1:0] ptr,
    output logic [IDX_W-1:0] idx,
    output logic             any
);

    logic [IDX_W-1:0] cand;

    always_comb begin
        // NOTE: every output of a combinational block gets a default before
        // any conditional assignment, otherwise synthesis infers a latch.
        idx  = '0;
        any  = 1'b0;
        cand = '0;
        // Walk from the farthest offset back to ptr so the closest hit wins.
        for (int i = N_REQ - 1; i >= 0; i--) begin
            cand = ptr + IDX_W'(i);
            if (req[cand]) begin
                idx = cand;
                any = 1'b1;
            end
        end
    end

endmodule

// File: rtl/rr_arb4_sel.sv
// Round-robin arbiter producing the registered grant index for the 2-to-4
// decoder. Optional forced release after MAX_HOLD cycles under ARB_TIMEOUT_EN.
module rr_arb4_sel
    import arb_pkg::*;
#(
    parameter int MAX_HOLD = 16
) (
    input  logic               clk,
    input  logic               rst_n,
    rr_arb4_sel_if.slave       bus
);

    state_t           state_q, state_d;
    logic [IDX_W-1:0] ptr_q, ptr_d;
    logic [IDX_W-1:0] gnt_idx_q, gnt_idx_d;
    logic [IDX_W-1:0] pick_ptr, pick_idx;
    logic             pick_any;
    logic             rel_now;
    logic             timeout_hit;

    // While busy the picker already searches from the post-release pointer,
    // so a release can hand over in the same edge.
    assign pick_ptr = (state_q == ST_BUSY) ? gnt_idx_q + IDX_W'(1) : ptr_q;
    assign rel_now  = (state_q == ST_BUSY) && (bus.ack || timeout_hit);

    rr_pick4 u_pick (
        .req (bus.req),
        .ptr (pick_ptr),
        .idx (pick_idx),
        .any (pick_any)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= ST_IDLE;
            ptr_q     <= '0;
            gnt_idx_q <= '0;
        end else begin
            // NOTE: sequential state uses non-blocking assignments so every
            // flop samples pre-edge values regardless of statement order.
            state_q   <= state_d;
            ptr_q     <= ptr_d;
            gnt_idx_q <= gnt_idx_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ST_IDLE: if (pick_any) state_d = ST_BUSY;
            ST_BUSY: if (rel_now && !pick_any) state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        ptr_d     = ptr_q;
        gnt_idx_d = gnt_idx_q;
        if (state_q == ST_IDLE) begin
            if (pick_any) gnt_idx_d = pick_idx;
        end else if (rel_now) begin
            ptr_d = gnt_idx_q + IDX_W'(1);
            if (pick_any) gnt_idx_d = pick_idx;
        end
    end

    assign bus.gnt_idx   = gnt_idx_q;
    assign bus.gnt_valid = (state_q == ST_BUSY);

`ifdef ARB_TIMEOUT_EN
    logic [7:0] hold_cnt;
    logic       tmo_q;

    // ack has priority: a coinciding ack is a normal release, not a timeout.
    assign timeout_hit = (state_q == ST_BUSY) && !bus.ack &&
                         (hold_cnt == 8'(MAX_HOLD - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hold_cnt <= '0;
            tmo_q    <= 1'b0;
        end else begin
            tmo_q <= timeout_hit;
            if (state_q == ST_IDLE || rel_now) hold_cnt <= '0;
            else                               hold_cnt <= hold_cnt + 8'd1;
        end
    end

    assign bus.tmo = tmo_q;
`else
    assign timeout_hit = 1'b0;
    assign bus.tmo     = 1'b0;
`endif

endmodule

// File: tb/tb_rr_arb4_sel.sv
// Directed bench for rr_arb4_sel; each comparison checks the packed
// {gnt_valid, gnt_idx, tmo} against a hand-computed value.
module tb_rr_arb4_sel;

    logic clk;
    logic rst_n;
    int   n_checks;
    int   n_fail;

    rr_arb4_sel_if bus ();

    rr_arb4_sel #(.MAX_HOLD(4)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Outputs are sampled and inputs changed 1 ns after each rising edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_n   = 1'b0;
        bus.req = 4'b0000;
        bus.ack = 1'b0;
        #12;
        n_checks++;
        if ({bus.gnt_valid, bus.gnt_idx, bus.tmo} !== 4'b0000) begin
            n_fail++;
            $display("FAIL reset_hold: got %b expected 0000", {bus.gnt_valid, bus.gnt_idx, bus.tmo});
        end
        #5 rst_n = 1'b1;
        step();
        for (int c = 0; c < 5; c++) begin
            n_checks++;
            if ({bus.gnt_valid, bus.gnt_idx, bus.tmo} !== 4'b0000) begin
                n_fail++;
                $display("FAIL idle_no_req cyc%0d: got %b expected 0000", c, {bus.gnt_valid, bus.gnt_idx, bus.tmo});
            end
            step();
        end
    endtask

    task automatic test_basic();
        // ptr=0, req 1010 -> requester 1; ack -> ptr=2 -> requester 3.
        bus.req = 4'b1010;
        step();
        n_checks++;
        if ({bus.gnt_valid, bus.gnt_idx, bus.tmo} !== 4'b1010) begin
            n_fail++;
            $display("FAIL first_grant: got %b expected 1010", {bus.gnt_valid, bus.gnt_idx, bus.tmo});
        end
        bus.ack = 1'b1;
        step();
        bus.ack = 1'b0;
        n_checks++;
        if ({bus.gnt_valid, bus.gnt_idx, bus.tmo} !== 4'b1110) begin
            n_fail++;
            $display("FAIL back_to_back: got %b expected 1110", {bus.gnt_valid, bus.gnt_idx, bus.tmo});
        end
        bus.req = 4'b0000;
        bus.ack = 1'b1;
        step();
        bus.ack = 1'b0;
        n_checks++;
        if (bus.gnt_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL release_to_idle: got %b expected 0", bus.gnt_valid);
        end
        // ack while idle must not disturb anything.
        bus.ack = 1'b1;
        step();
        bus.ack = 1'b0;
        n_checks++;
        if (bus.gnt_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL ack_in_idle: got %b expected 0", bus.gnt_valid);
        end
    endtask

    task automatic test_rotation();
        // ptr back at 0 after the previous release of requester 3.
        bus.req = 4'b1111;
        step();
        for (int g = 0; g < 5; g++) begin
            for (int c = 0; c < 3; c++) begin
                n_checks++;
                if ({bus.gnt_valid, bus.gnt_idx} !== {1'b1, 2'(g % 4)}) begin
                    n_fail++;
                    $display("FAIL rotation g%0d c%0d: got %b expected %b", g, c, {bus.gnt_valid, bus.gnt_idx}, {1'b1, 2'(g % 4)});
                end
                bus.ack = (c == 2);
                step();
            end
        end
        // Now requester 1 holds; release it to idle, leaving ptr=2.
        bus.req = 4'b0000;
        bus.ack = 1'b1;
        step();
        bus.ack = 1'b0;
        n_checks++;
        if (bus.gnt_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL rotation_idle: got %b expected 0", bus.gnt_valid);
        end
    endtask

    task automatic test_req_drop();
        bus.req = 4'b0100;
        step();
        bus.req = 4'b0000;
        for (int c = 0; c < 3; c++) begin
            n_checks++;
            if ({bus.gnt_valid, bus.gnt_idx, bus.tmo} !== 4'b1100) begin
                n_fail++;
                $display("FAIL req_drop c%0d: got %b expected 1100", c, {bus.gnt_valid, bus.gnt_idx, bus.tmo});
            end
            if (c < 2) step();
        end
        bus.ack = 1'b1;
        step();
        bus.ack = 1'b0;
        n_checks++;
        if (bus.gnt_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL req_drop_release: got %b expected 0", bus.gnt_valid);
        end
    endtask

`ifdef ARB_TIMEOUT_EN
    task automatic test_timeout();
        // ptr=3, sole requester 0.
        bus.req = 4'b0001;
        step();
        for (int c = 1; c <= 4; c++) begin
            n_checks++;
            if ({bus.gnt_valid, bus.gnt_idx, bus.tmo} !== 4'b1000) begin
                n_fail++;
                $display("FAIL timeout_hold c%0d: got %b expected 1000", c, {bus.gnt_valid, bus.gnt_idx, bus.tmo});
            end
            step();
        end
        // Forced release, requester 0 re-granted with a tmo pulse.
        for (int c = 1; c <= 4; c++) begin
            n_checks++;
            if ({bus.gnt_valid, bus.gnt_idx, bus.tmo} !== {3'b100, c == 1}) begin
                n_fail++;
                $display("FAIL timeout_regrant c%0d: got %b expected %b", c, {bus.gnt_valid, bus.gnt_idx, bus.tmo}, {3'b100, c == 1});
            end
            bus.ack = (c == 4);
            step();
        end
        bus.ack = 1'b0;
        n_checks++;
        if ({bus.gnt_valid, bus.gnt_idx, bus.tmo} !== 4'b1000) begin
            n_fail++;
            $display("FAIL ack_beats_timeout: got %b expected 1000", {bus.gnt_valid, bus.gnt_idx, bus.tmo});
        end
        bus.req = 4'b0000;
        bus.ack = 1'b1;
        step();
        bus.ack = 1'b0;
    endtask
`else
    task automatic test_timeout();
        // Without the timeout feature a grant is held indefinitely.
        bus.req = 4'b0001;
        step();
        for (int c = 0; c < 8; c++) begin
            n_checks++;
            if ({bus.gnt_valid, bus.gnt_idx, bus.tmo} !== 4'b1000) begin
                n_fail++;
                $display("FAIL no_timeout c%0d: got %b expected 1000", c, {bus.gnt_valid, bus.gnt_idx, bus.tmo});
            end
            step();
        end
        bus.req = 4'b0000;
        bus.ack = 1'b1;
        step();
        bus.ack = 1'b0;
    endtask
`endif

    task automatic test_async_reset();
        // ptr=1 here; requester 3 only.
        bus.req = 4'b1000;
        step();
        n_checks++;
        if ({bus.gnt_valid, bus.gnt_idx, bus.tmo} !== 4'b1110) begin
            n_fail++;
            $display("FAIL pre_reset_grant: got %b expected 1110", {bus.gnt_valid, bus.gnt_idx, bus.tmo});
        end
        bus.req = 4'b1111;
        #3 rst_n = 1'b0;
        #1;
        n_checks++;
        if ({bus.gnt_valid, bus.gnt_idx, bus.tmo} !== 4'b0000) begin
            n_fail++;
            $display("FAIL async_reset: got %b expected 0000", {bus.gnt_valid, bus.gnt_idx, bus.tmo});
        end
        #2 rst_n = 1'b1;
        step();
        // ptr returned to 0, so all-request picks requester 0.
        n_checks++;
        if ({bus.gnt_valid, bus.gnt_idx, bus.tmo} !== 4'b1000) begin
            n_fail++;
            $display("FAIL post_reset_grant: got %b expected 1000", {bus.gnt_valid, bus.gnt_idx, bus.tmo});
        end
        bus.req = 4'b0000;
        bus.ack = 1'b1;
        step();
        bus.ack = 1'b0;
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        test_reset();
        test_basic();
        test_rotation();
        test_req_drop();
        test_timeout();
        test_async_reset();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
